// File: rtl/systolic_pkg.sv
//------------------------------------------------------------------------------
// Module   : systolic_pkg
// Purpose  : Shared types and helpers for the systolic result drain.
//            - drain_state_e : IDLE / DRAIN / DONE, 2-bit encoding
//            - result_row_t  : packed row of c_L results, c_WIDTH bits each
//            - addr_wrap_add : (base + offset) mod entries for any entries
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package systolic_pkg;

    localparam int c_L     = 8;
    localparam int c_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } drain_state_e;

    typedef logic [c_L-1:0][c_WIDTH-1:0] result_row_t;

    // Both operands are below 'entries', so the sum is below 2*entries and a
    // single conditional subtract is a full modulo reduction. This keeps the
    // wrap correct for depths that are not a power of two.
    function automatic logic [31:0] addr_wrap_add(input logic [31:0] base,
                                                  input logic [31:0] offset,
                                                  input logic [31:0] entries);
        logic [31:0] sum;
        sum = base + offset;
        if (sum >= entries) begin
            sum = sum - entries;
        end
        return sum;
    endfunction

endpackage

`default_nettype wire

// File: rtl/skew_delay_line.sv
//------------------------------------------------------------------------------
// Module   : skew_delay_line
// Purpose  : Fixed-length shift register used to de-skew one result column.
//            DEPTH = 0 is a plain wire (no flops).
// Ports    : clk  - clock
//            rst  - asynchronous active-low reset, clears every stage
//            d    - WIDTH-bit input, shifted in every cycle
//            q    - input delayed by DEPTH cycles
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q = d;
            // Clock and reset have no load in the pass-through column.
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk ^ rst;
        end else begin : g_pipe
            logic [DEPTH-1:0][WIDTH-1:0] r_stage;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_stage <= '0;
                end else begin
                    r_stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/systolic_drain.sv
//------------------------------------------------------------------------------
// Module   : systolic_drain
// Purpose  : Collects skewed per-column results from an L-wide systolic array,
//            re-aligns them into whole rows and writes each row into the
//            result SRAM at (base_addr + row) mod ENTRYS.
// Ports    : clk, rst (async active-low)
//            start, rows, base_addr    - drain command (accepted in IDLE only)
//            res_valid, res_data       - skewed column results
//            wr_en, wr_addr, wr_data   - registered SRAM write port
//            busy, done, skew_err      - status
// Options  : SYSTOLIC_DRAIN_SKEW_CHECK_EN - when defined, builds a sticky
//            flag that reports any cycle in DRAIN where the de-skewed column
//            valids disagree. When undefined skew_err is tied low.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module systolic_drain
    import systolic_pkg::*;
#(
    parameter int L      = 8,
    parameter int ENTRYS = 1024,
    parameter int WIDTH  = 32,
    parameter int AW     = $clog2(ENTRYS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [AW:0]             rows,
    input  logic [AW-1:0]           base_addr,
    input  logic [L-1:0]            res_valid,
    input  logic [L-1:0][WIDTH-1:0] res_data,
    output logic                    wr_en,
    output logic [AW-1:0]           wr_addr,
    output logic [L-1:0][WIDTH-1:0] wr_data,
    output logic                    busy,
    output logic                    done,
    output logic                    skew_err
);

    drain_state_e              r_state;
    logic [AW:0]               r_rows;
    logic [AW-1:0]             r_base;
    logic [AW:0]               r_row_cnt;
    logic                      r_wr_en;
    logic [AW-1:0]             r_wr_addr;
    logic [L-1:0][WIDTH-1:0]   r_wr_data;

    logic                      w_in_drain;
    logic [L-1:0]              w_in_valid;
    logic [L-1:0]              w_dly_valid;
    logic [L-1:0][WIDTH-1:0]   w_dly_data;
    logic [AW-1:0]             w_addr_next;
    logic                      w_start_accept;

    assign w_in_drain     = (r_state == ST_DRAIN);
    assign w_start_accept = (r_state == ST_IDLE) && start;

    // Results arriving outside DRAIN never enter the delay lines, so stale
    // or trailing valids cannot turn into writes later.
    assign w_in_valid = res_valid & {L{w_in_drain}};

    // Column j arrives j cycles after column 0, so it needs L-1-j stages to
    // line up with column 0 (which gets the full L-1 stages).
    generate
        for (genvar j = 0; j < L; j++) begin : g_col
            skew_delay_line #(
                .DEPTH (L - 1 - j),
                .WIDTH (WIDTH + 1)
            ) u_dly (
                .clk (clk),
                .rst (rst),
                .d   ({w_in_valid[j], res_data[j]}),
                .q   ({w_dly_valid[j], w_dly_data[j]})
            );
        end
    endgenerate

    // row_cnt is kept below ENTRYS while draining, so the sum fits AW+1 bits.
    assign w_addr_next = AW'(addr_wrap_add(32'(r_base), 32'(r_row_cnt), ENTRYS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_rows    <= '0;
            r_base    <= '0;
            r_row_cnt <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_rows    <= rows;
                        r_base    <= base_addr;
                        r_row_cnt <= '0;
                        r_state   <= (rows == '0) ? ST_DONE : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Column 0 carries the row strobe for the aligned row.
                    if (w_dly_valid[0]) begin
                        r_wr_en   <= 1'b1;
                        r_wr_data <= w_dly_data;
                        r_wr_addr <= w_addr_next;
                        r_row_cnt <= r_row_cnt + 1'b1;
                        if (r_row_cnt == r_rows - 1'b1) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = (r_state == ST_DRAIN);
    assign done    = (r_state == ST_DONE);

`ifdef SYSTOLIC_DRAIN_SKEW_CHECK_EN
    logic r_skew_err;
    logic w_valid_mismatch;

    assign w_valid_mismatch = !((&w_dly_valid) || (~|w_dly_valid));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_skew_err <= 1'b0;
        end else if (w_start_accept) begin
            r_skew_err <= 1'b0;
        end else if (w_in_drain && w_valid_mismatch) begin
            r_skew_err <= 1'b1;
        end
    end

    assign skew_err = r_skew_err;
`else
    assign skew_err = 1'b0;
    // Only column 0's delayed valid steers writes; the others feed the
    // optional checker and are otherwise left without a load.
    logic w_unused_skew;
    assign w_unused_skew = (^w_dly_valid) ^ w_start_accept;
`endif

endmodule

`default_nettype wire
